sha_msg_schedule: RTL
=====================

Name: sha_msg_schedule

Overview:
- Message-schedule stage directly upstream of the SHA round datapath.
- Accepts one padded message block and streams one schedule word W_t per cycle, for 64 rounds (SHA-256) or 80 rounds (SHA-512).
- Generates round index, first-round `init` and end-of-block `done` strobes; these drive the round stage's W/K/init/done inputs.
- A single `mode` input selects SHA-512 (1) or SHA-256 (0), matching the round stage's convention.

Parameters:
- RND512, 80, round count when mode=1
- RND256, 64, round count when mode=0

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  block request; accepted only while ready=1
- mode  input  1  1=SHA-512 (64-bit words), 0=SHA-256 (32-bit words); sampled at accepted start
- block_in  input  1024  padded block. mode=1: M0=[1023:960] … M15=[63:0]. mode=0: M0=[511:480] … M15=[31:0]; [1023:512] ignored.
- ready  output  1  high in IDLE only
- w_valid  output  1  high while W/round_idx are valid
- W  output  64  schedule word; mode=0 places it in [31:0], with [63:32]=0
- K  output  64  round constant (see Optional Feature)
- round_idx  output  7  current round t
- init  output  1  one-cycle pulse coincident with round 0
- done  output  1  one-cycle pulse the cycle after the last round
- mode_q  output  1  latched mode for downstream

Behaviour:
- Reset (rst_n=0 at a clk edge) values: ready=1, w_valid=0, W=0, K=0, round_idx=0, init=0, done=0, mode_q=0. Internal state returns to IDLE and the window is cleared.
- Reset asserted mid-block aborts the block immediately; no done pulse is issued.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge T latches block_in into a 16-word window w[0..15] (w[0]=M0) and latches mode into mode_q.
  - Sets round_idx=0 and moves to RUN.
- RUN:
  - Each cycle: w_valid=1, W=w[0], round_idx=t; init=1 only when t=0.
  - At each edge the window shifts down: w[i]<=w[i+1], and w[15]<=σ1(w[14])+w[9]+σ0(w[1])+w[0]. Addition is mod 2^64 for mode=1 and mod 2^32 for mode=0; upper 32 bits are forced to 0 in mode=0.
  - This gives W_t=M_t for t<16 and the standard recurrence for t≥16.
  - When t=N-1 (N=RND512 or RND256 per mode_q), go to FIN.
- FIN: w_valid=0, done=1 for exactly one cycle, then go to IDLE (ready=1 the following cycle).
- Latency:
  - Accepted start at edge T → W_0 visible in cycle T+1.
  - W_{N-1} in cycle T+N; done in cycle T+N+1; ready in cycle T+N+2.
- Sigma functions:
  - mode=0: σ0=ROTR7^ROTR18^SHR3, σ1=ROTR17^ROTR19^SHR10 (32-bit).
  - mode=1: σ0=ROTR1^ROTR8^SHR7, σ1=ROTR19^ROTR61^SHR6 (64-bit).
- start while ready=0 is ignored and has no side effect.
- Changes on mode/block_in after acceptance have no effect on the block in flight.
- start asserted in the same cycle as done is ignored (ready=0 in FIN).
- round_idx never exceeds N-1 and holds its last value in FIN/IDLE.
- No back-pressure: the consumer must absorb one word per cycle.

Optional Feature:
- Macro: SHA_MSG_KROM_EN.
- Defined: an internal constant table drives K with K_t for round_idx, registered alongside W.
  - mode=1: 64-bit SHA-512 constants.
  - mode=0: SHA-256 constants in [31:0], with [63:32]=0.
- Undefined: K is tied to 0 and the consumer indexes its own table via round_idx.

Decomposition:
- Shared include/package sha_pkg:
  - FSM state encodings (IDLE/FIN/RUN)
  - RND512/RND256 defaults
  - word-width constants
  - the 80×64 and 64×32 K tables
- Sub-module sha_msg_sigma: combinational σ0/σ1 for both modes, mode input, 64-bit in/out. Instanced once for σ0 and once for σ1, or as one module with both outputs.
- FSM, counter and window stay in sha_msg_schedule.

Test Plan:
- mode=0, "abc" padded block (M0=0x61626380, M15=0x00000018, others 0), start pulse → W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000. init in the same cycle as W0; 64 w_valid cycles; done at T+65.
- mode=1, "abc" block (M0=0x6162638000000000, M15=0x18) → W16=0x6162638000000000, W17=0x00030000000000C0; 80 w_valid cycles; done at T+81.
- start held high continuously → exactly one block per start acceptance; next block begins at the edge after ready rises; start during RUN/FIN is ignored.
- rst_n=0 at round 30 → next cycle ready=1, w_valid=0, W=0, no done. Then a fresh start reproduces the "abc" W sequence exactly.
- Toggle mode and block_in during RUN → output sequence is identical to the undisturbed run.
- With SHA_MSG_KROM_EN: mode=0 round 0 K=0x00000000428A2F98; mode=1 round 79 K=0x6C44198C4A475817. Without the macro, K=0 in all rounds.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA message-schedule types, sizes and round-constant table.
// K256 is not stored separately: each SHA-256 constant is the top half of the SHA-512 one.
package sha_pkg;

    localparam int RND512_DEF = 80;
    localparam int RND256_DEF = 64;
    localparam int WORD64     = 64;
    localparam int WORD32     = 32;
    localparam int NWIN       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [63:0] K512 [RND512_DEF] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [63:0] k_lookup(
        input logic       m,
        input logic [6:0] t
    );
        if (m)
            return K512[t];
        return {32'h0, K512[{1'b0, t[5:0]}][63:32]};
    endfunction

endpackage

// File: rtl/sha_msg_sigma.sv
// Combinational sigma0/sigma1 for SHA-256 (mode=0) and SHA-512 (mode=1).
module sha_msg_sigma
    import sha_pkg::*;
(
    input  logic              mode,
    input  logic [WORD64-1:0] x0,
    input  logic [WORD64-1:0] x1,
    output logic [WORD64-1:0] s0,
    output logic [WORD64-1:0] s1
);

    logic [WORD32-1:0] a;
    logic [WORD32-1:0] b;

    assign a = x0[WORD32-1:0];
    assign b = x1[WORD32-1:0];

    always_comb begin
        s0 = '0;
        s1 = '0;
        if (mode) begin
            s0 = {x0[0], x0[63:1]}
               ^ {x0[7:0], x0[63:8]}
               ^ (x0 >> 7);
            s1 = {x1[18:0], x1[63:19]}
               ^ {x1[60:0], x1[63:61]}
               ^ (x1 >> 6);
        end else begin
            s0[31:0] = {a[6:0], a[31:7]}
                     ^ {a[17:0], a[31:18]}
                     ^ (a >> 3);
            s1[31:0] = {b[16:0], b[31:17]}
                     ^ {b[18:0], b[31:19]}
                     ^ (b >> 10);
        end
    end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256/512 message schedule: streams W_t one per cycle into the round stage.
// Optional macro SHA_MSG_KROM_EN adds a registered K_t output from the constant table.
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter int RND512 = RND512_DEF,
    parameter int RND256 = RND256_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [1023:0] block_in,
    output logic          ready,
    output logic          w_valid,
    output logic [63:0]   W,
    output logic [63:0]   K,
    output logic [6:0]    round_idx,
    output logic          init,
    output logic          done,
    output logic          mode_q
);

    state_t      state;
    logic [63:0] win [NWIN];
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] nxt;
    logic [6:0]  last;

    sha_msg_sigma u_sigma (
        .mode (mode_q),
        .x0   (win[1]),
        .x1   (win[14]),
        .s0   (s0),
        .s1   (s1)
    );

    assign last = mode_q ? 7'(RND512 - 1) : 7'(RND256 - 1);
    assign W    = win[0];

    always_comb begin
        nxt = s1 + win[9] + s0 + win[0];
        if (!mode_q)
            nxt[63:32] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            w_valid   <= 1'b0;
            round_idx <= '0;
            init      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= 1'b0;
            for (int i = 0; i < NWIN; i++)
                win[i] <= '0;
        end else begin
            init <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NWIN; i++)
                            win[i] <= mode
                                ? block_in[1023-64*i -: 64]
                                : {32'h0, block_in[511-32*i -: 32]};
                        mode_q    <= mode;
                        round_idx <= '0;
                        w_valid   <= 1'b1;
                        init      <= 1'b1;
                        ready     <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NWIN - 1; i++)
                        win[i] <= win[i+1];
                    win[NWIN-1] <= nxt;
                    if (round_idx == last) begin
                        w_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        round_idx <= round_idx + 7'd1;
                    end
                end
                FIN: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA_MSG_KROM_EN
    logic [63:0] k_q;

    // K follows the same load/advance edges as the window so it lines up with W.
    always_ff @(posedge clk) begin
        if (!rst_n)
            k_q <= '0;
        else if (state == IDLE && start)
            k_q <= k_lookup(mode, 7'd0);
        else if (state == RUN && round_idx != last)
            k_q <= k_lookup(mode_q, round_idx + 7'd1);
    end

    assign K = k_q;
`else
    assign K = '0;
`endif

endmodule
